// File: rtl/audio_mix_pkg.sv
// Shared types and constants for the voice mixer / frame scheduler.
package audio_mix_pkg;

  localparam int SAMPLE_W_DEF = 32;

  typedef enum logic [1:0] {IDLE, SCAN, WAIT, WRITE} state_e;

  // Accumulator width: one sign bit plus headroom for summing nv full-scale samples.
  function automatic int acc_w(input int nv, input int sw);
    return sw + $clog2(nv) + 1;
  endfunction

  localparam int ACC_W_DEF = acc_w(4, SAMPLE_W_DEF);

endpackage

// File: rtl/mix_sat.sv
// Accumulator-to-sample limiter, one per stereo channel.
// VOICE_MIX_SAT_EN defined: clamp to the signed SAMPLE_W range.
// VOICE_MIX_SAT_EN undefined: keep the low SAMPLE_W bits (two's-complement wrap).
module mix_sat #(
  parameter int ACC_W    = 35,
  parameter int SAMPLE_W = 32
) (
  input  logic [ACC_W-1:0]    acc,
  output logic [SAMPLE_W-1:0] res
);

`ifdef VOICE_MIX_SAT_EN
  // Bits that must all match the sign for the value to fit in SAMPLE_W.
  logic [ACC_W-SAMPLE_W:0] hi;
  assign hi = acc[ACC_W-1:SAMPLE_W-1];

  // Pass through when in range, otherwise clamp toward the sign of acc.
  always_comb begin
    res = acc[SAMPLE_W-1:0];
    if (!(&hi) && (|hi))
      res = acc[ACC_W-1] ? {1'b1, {(SAMPLE_W-1){1'b0}}} : {1'b0, {(SAMPLE_W-1){1'b1}}};
  end
`else
  logic unused_hi;
  assign unused_hi = ^acc[ACC_W-1:SAMPLE_W];
  assign res       = acc[SAMPLE_W-1:0];
`endif

endmodule

// File: rtl/voice_mix_sched.sv
// Frame scheduler and mixer: polls each voice in index order once per frame,
// sums stereo contributions and writes one {L,R} word into audio_out's FIFO.
// Optional clamping of the mixed word is selected by VOICE_MIX_SAT_EN.
module voice_mix_sched
  import audio_mix_pkg::*;
#(
  parameter int NUM_VOICES = 4,
  parameter int SAMPLE_W   = SAMPLE_W_DEF,
  parameter int WAIT_MAX   = 16
) (
  input  logic                           clk,
  input  logic                           aclr_n,
  input  logic                           enable,
  input  logic [NUM_VOICES-1:0]          voice_mute,
  output logic [NUM_VOICES-1:0]          voice_rd,
  input  logic [NUM_VOICES-1:0]          voice_valid,
  input  logic [NUM_VOICES*2*SAMPLE_W-1:0] voice_sample,
  output logic [2*SAMPLE_W-1:0]          sample,
  output logic                           wrreq,
  input  logic                           wrfull,
  output logic                           busy,
  output logic [15:0]                    frame_cnt,
  output logic [15:0]                    underrun_cnt
);

  localparam int ACC_W = acc_w(NUM_VOICES, SAMPLE_W);
  localparam int IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;
  localparam int TMR_W = $clog2(WAIT_MAX + 1);

  state_e             state_q, state_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic [TMR_W-1:0]   timer_q, timer_d;
  logic [ACC_W-1:0]   acc_l_q, acc_l_d, acc_r_q, acc_r_d;
  logic [15:0]        frame_cnt_q, frame_cnt_d, underrun_q, underrun_d;
  logic               adv;

  // Current voice slice, {L, R}
  logic [NUM_VOICES-1:0][2*SAMPLE_W-1:0] vs;
  logic [2*SAMPLE_W-1:0]                 cur;
  logic [SAMPLE_W-1:0]                   cur_l, cur_r;
  logic                                  last;

  assign vs    = voice_sample;
  assign cur   = vs[idx_q];
  assign cur_l = cur[2*SAMPLE_W-1:SAMPLE_W];
  assign cur_r = cur[SAMPLE_W-1:0];
  assign last  = (idx_q == IDX_W'(NUM_VOICES - 1));

  // State and datapath registers
  always_ff @(posedge clk or negedge aclr_n) begin
    if (!aclr_n) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      timer_q     <= '0;
      acc_l_q     <= '0;
      acc_r_q     <= '0;
      frame_cnt_q <= '0;
      underrun_q  <= '0;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      timer_q     <= timer_d;
      acc_l_q     <= acc_l_d;
      acc_r_q     <= acc_r_d;
      frame_cnt_q <= frame_cnt_d;
      underrun_q  <= underrun_d;
    end
  end

  // Next state, voice walk, accumulation and counters
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    timer_d     = timer_q;
    acc_l_d     = acc_l_q;
    acc_r_d     = acc_r_q;
    frame_cnt_d = frame_cnt_q;
    underrun_d  = underrun_q;
    adv         = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !wrfull) begin
          acc_l_d = '0;
          acc_r_d = '0;
          idx_d   = '0;
          state_d = SCAN;
        end
      end
      SCAN: begin
        if (voice_mute[idx_q]) begin
          adv = 1'b1;
        end else begin
          timer_d = '0;
          state_d = WAIT;
        end
      end
      WAIT: begin
        // Valid wins over a coincident timeout.
        if (voice_valid[idx_q]) begin
          acc_l_d = acc_l_q + {{(ACC_W-SAMPLE_W){cur_l[SAMPLE_W-1]}}, cur_l};
          acc_r_d = acc_r_q + {{(ACC_W-SAMPLE_W){cur_r[SAMPLE_W-1]}}, cur_r};
          adv     = 1'b1;
        end else if (timer_q == TMR_W'(WAIT_MAX - 1)) begin
          if (underrun_q != 16'hFFFF) underrun_d = underrun_q + 16'd1;
          adv = 1'b1;
        end else begin
          timer_d = timer_q + TMR_W'(1);
        end
      end
      WRITE: begin
        if (!wrfull) begin
          frame_cnt_d = frame_cnt_q + 16'd1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (adv) begin
      if (last) begin
        state_d = WRITE;
      end else begin
        idx_d   = idx_q + IDX_W'(1);
        state_d = SCAN;
      end
    end
  end

  // Strobes and status outputs
  always_comb begin
    voice_rd = '0;
    if (state_q == SCAN && !voice_mute[idx_q]) voice_rd[idx_q] = 1'b1;
    wrreq        = (state_q == WRITE) && !wrfull;
    busy         = (state_q != IDLE);
    frame_cnt    = frame_cnt_q;
    underrun_cnt = underrun_q;
  end

  // sample always reflects the limited accumulators, so it holds the last
  // frame until the next frame start clears them.
  mix_sat #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W)) u_sat_l (
    .acc (acc_l_q),
    .res (sample[2*SAMPLE_W-1:SAMPLE_W])
  );

  mix_sat #(.ACC_W(ACC_W), .SAMPLE_W(SAMPLE_W)) u_sat_r (
    .acc (acc_r_q),
    .res (sample[SAMPLE_W-1:0])
  );

endmodule

// File: tb/tb_voice_mix_sched.sv
// Scoreboard bench for voice_mix_sched: expected frame words are queued when a
// frame is launched and popped when wrreq is seen.
module tb_voice_mix_sched;

  localparam int NV = 4;
  localparam int SW = 32;
  localparam int WM = 16;

  logic                 clk = 1'b0;
  logic                 aclr_n = 1'b0;
  logic                 enable = 1'b0;
  logic                 wrfull = 1'b0;
  logic [NV-1:0]        voice_mute = '0;
  logic [NV-1:0]        voice_valid = '0;
  logic [NV-1:0]        voice_rd;
  logic [NV*2*SW-1:0]   voice_sample = '0;
  logic [2*SW-1:0]      sample;
  logic                 wrreq, busy;
  logic [15:0]          frame_cnt, underrun_cnt;

  voice_mix_sched #(.NUM_VOICES(NV), .SAMPLE_W(SW), .WAIT_MAX(WM)) dut (
    .clk          (clk),
    .aclr_n       (aclr_n),
    .enable       (enable),
    .voice_mute   (voice_mute),
    .voice_rd     (voice_rd),
    .voice_valid  (voice_valid),
    .voice_sample (voice_sample),
    .sample       (sample),
    .wrreq        (wrreq),
    .wrfull       (wrfull),
    .busy         (busy),
    .frame_cnt    (frame_cnt),
    .underrun_cnt (underrun_cnt)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int          n_cmp = 0, n_err = 0;
  logic [63:0] exp_q[$];
  int          wr_cnt = 0, wr_cyc = 0, t0 = 0, rel = 0;
  int          rd_cyc[NV];
  int          lv[NV], rv[NV];
  logic [NV-1:0] rd_seen = '0, dead = '0, pend = '0;
  logic [15:0] f0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] sat32(input longint s);
`ifdef VOICE_MIX_SAT_EN
    if (s > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (s < -64'sd2147483648) return 32'h8000_0000;
`endif
    return s[31:0];
  endfunction

  // Reference mix of the configured voices (muted or silent voices add 0).
  function automatic logic [63:0] mix_exp();
    longint sl = 0, sr = 0;
    for (int v = 0; v < NV; v++)
      if (!voice_mute[v] && !dead[v]) begin
        sl += longint'(lv[v]);
        sr += longint'(rv[v]);
      end
    return {sat32(sl), sat32(sr)};
  endfunction

  task automatic set_voices(input int l, input int r);
    for (int v = 0; v < NV; v++) begin
      lv[v] = l;
      rv[v] = r;
      voice_sample[v*2*SW +: 2*SW] = {l, r};
    end
  endtask

  // Voice generator model: valid exactly one cycle after its strobe.
  initial begin
    forever begin
      @(posedge clk); #1;
      voice_valid = pend;
      pend = '0;
      if (aclr_n)
        for (int v = 0; v < NV; v++)
          if (voice_rd[v] && !dead[v]) pend[v] = 1'b1;
    end
  end

  // Output monitor: pops the scoreboard on every write, logs strobes.
  initial begin
    forever begin
      @(negedge clk);
      if (aclr_n) begin
        if (wrreq) begin
          wr_cnt++;
          wr_cyc = cyc;
          if (exp_q.size() > 0) chk("sample", sample, exp_q.pop_front());
          else                  chk("wrreq_unexpected", {63'b0, wrreq}, 64'd0);
        end
        for (int v = 0; v < NV; v++)
          if (voice_rd[v]) begin
            rd_cyc[v]  = cyc;
            rd_seen[v] = 1'b1;
          end
      end
    end
  end

  // Launch one frame; enable held for rel cycles [0,drop), wrfull for [fs,fe).
  task automatic run_frame(input int drop, input int fs, input int fe, output int r);
    int w0;
    w0 = wr_cnt;
    rd_seen = '0;
    @(posedge clk); #1;
    t0 = cyc;
    enable = 1'b1;
    wrfull = 1'b0;
    for (int k = 0; k < 400 && wr_cnt == w0; k++) begin
      @(posedge clk); #1;
      enable = ((cyc - t0) < drop);
      wrfull = ((cyc - t0) >= fs) && ((cyc - t0) < fe);
    end
    enable = 1'b0;
    wrfull = 1'b0;
    chk("wr_seen", 64'(wr_cnt != w0), 64'd1);
    r = wr_cyc - t0;
  endtask

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_sample", sample, 64'd0);
    chk("rst_wrreq", 64'(wrreq), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_voice_rd", 64'(voice_rd), 64'd0);
    chk("rst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("rst_underrun", 64'(underrun_cnt), 64'd0);
    @(posedge clk); #1;
    aclr_n = 1'b1;

    // Basic mix
    set_voices(1000, -200);
    exp_q.push_back(mix_exp());
    run_frame(1, 999, 999, rel);
    chk("basic_wr_lat", 64'(rel), 64'd9);
    for (int v = 0; v < NV; v++) chk("basic_rd_cyc", 64'(rd_cyc[v] - t0), 64'(1 + 2*v));
    chk("basic_rd_seen", 64'(rd_seen), 64'hF);
    @(negedge clk);
    chk("basic_frame_cnt", 64'(frame_cnt), 64'd1);
    chk("basic_hold", sample, 64'h0000_0FA0_FFFF_FCE0);

    // Saturation / wrap
    set_voices(32'h7000_0000, 32'h9000_0000);
    exp_q.push_back(mix_exp());
    run_frame(1, 999, 999, rel);
    @(negedge clk);
`ifdef VOICE_MIX_SAT_EN
    chk("sat_hold", sample, 64'h7FFF_FFFF_8000_0000);
`else
    chk("sat_hold", sample, 64'hC000_0000_4000_0000);
`endif

    // Mute of voice 1, voice 2 times out
    voice_mute = 4'b0010;
    dead       = 4'b0100;
    set_voices(5, 5);
    exp_q.push_back(mix_exp());
    run_frame(1, 999, 999, rel);
    chk("mute_rd_seen", 64'(rd_seen), 64'hD);
    chk("mute_wait_len", 64'(rd_cyc[3] - rd_cyc[2]), 64'(WM + 1));
    chk("mute_wr_lat", 64'(rel), 64'd23);
    @(negedge clk);
    chk("mute_underrun", 64'(underrun_cnt), 64'd1);
    chk("mute_hold", sample, {32'd10, 32'd10});
    dead = '0;

    // All voices muted: zero frame after NUM_VOICES scan cycles
    voice_mute = 4'hF;
    set_voices(9, 9);
    exp_q.push_back(mix_exp());
    run_frame(1, 999, 999, rel);
    chk("allmute_wr_lat", 64'(rel), 64'd5);
    chk("allmute_rd_seen", 64'(rd_seen), 64'd0);
    voice_mute = '0;

    // Back-pressure in WRITE
    set_voices(1, 2);
    exp_q.push_back(mix_exp());
    fork
      run_frame(1, 8, 20, rel);
      begin
        @(posedge clk); #2;
        while (cyc != t0 + 15) @(negedge clk);
        chk("bp_busy", 64'(busy), 64'd1);
        chk("bp_wrreq", 64'(wrreq), 64'd0);
        chk("bp_sample", sample, {32'd4, 32'd8});
      end
    join
    chk("bp_wr_lat", 64'(rel), 64'd20);

    // No frame start while wrfull in IDLE
    @(posedge clk); #1;
    wrfull  = 1'b1;
    enable  = 1'b1;
    rd_seen = '0;
    repeat (5) @(posedge clk);
    @(negedge clk);
    chk("idle_full_busy", 64'(busy), 64'd0);
    chk("idle_full_rd", 64'(rd_seen), 64'd0);
    @(posedge clk); #1;
    enable = 1'b0;
    wrfull = 1'b0;

    // Enable falls during SCAN of voice 2
    f0 = frame_cnt;
    set_voices(2, 3);
    exp_q.push_back(mix_exp());
    run_frame(5, 999, 999, rel);
    chk("drop_wr_lat", 64'(rel), 64'd9);
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("drop_busy", 64'(busy), 64'd0);
    chk("drop_frames", 64'(frame_cnt - f0), 64'd1);

    // Reset during WAIT of voice 1
    set_voices(7, 3);
    @(posedge clk); #1;
    t0 = cyc;
    enable = 1'b1;
    @(posedge clk); #1;
    enable = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    aclr_n = 1'b0;
    @(negedge clk);
    chk("mrst_voice_rd", 64'(voice_rd), 64'd0);
    chk("mrst_wrreq", 64'(wrreq), 64'd0);
    chk("mrst_sample", sample, 64'd0);
    chk("mrst_frame_cnt", 64'(frame_cnt), 64'd0);
    chk("mrst_underrun", 64'(underrun_cnt), 64'd0);
    chk("mrst_busy", 64'(busy), 64'd0);
    @(posedge clk); #1;
    aclr_n = 1'b1;
    exp_q.push_back(mix_exp());
    run_frame(1, 999, 999, rel);
    chk("mrst_wr_lat", 64'(rel), 64'd9);
    chk("mrst_first_rd", 64'(rd_cyc[0] - t0), 64'd1);
    @(negedge clk);
    chk("mrst_hold", sample, {32'd28, 32'd12});
    chk("mrst_frame_cnt_after", 64'(frame_cnt), 64'd1);
    chk("queue_drained", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
